// File: rtl/eth_flow_ctrl_gen_pkg.sv
// Shared constants, request kinds and the resume-level helper for the
// Ethernet pause / per-priority pause request generator.
package eth_fc_pkg;

    localparam int FC_MAX_CLASSES = 8;
    localparam int FC_QUANTA_1G   = 64;

    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_XOFF = 2'd1,
        FC_XON  = 2'd2
    } fc_kind_t;

    // A resume level at or below the pause level would let a lane bounce
    // straight between XOFF and XON; force at least one unit of hysteresis.
    function automatic logic [16:0] fc_resume_level(input logic [15:0] pause_thresh,
                                                    input logic [15:0] resume_thresh);
        if (resume_thresh > pause_thresh)
            return {1'b0, resume_thresh};
        else
            return {1'b0, pause_thresh} + 17'd1;
    endfunction

endpackage

// File: rtl/eth_flow_ctrl_gen_if.sv
// Pause request handshake towards the TX MAC: request, time and class vector
// are held stable by the master until the slave acknowledges.
interface eth_flow_ctrl_gen_if;
    import eth_fc_pkg::*;

    logic                      pause_req;
    logic                      pause_ack;
    logic [15:0]               pause_time_req;
    logic [FC_MAX_CLASSES-1:0] pause_class_vec;

    modport master (
        output pause_req,
        output pause_time_req,
        output pause_class_vec,
        input  pause_ack
    );

    modport slave (
        input  pause_req,
        input  pause_time_req,
        input  pause_class_vec,
        output pause_ack
    );

endinterface

// File: rtl/eth_flow_ctrl_gen_class.sv
// One traffic class: registered threshold compares, RUN/PAUSED state and the
// remaining-quanta counter; raises want_xoff / want_xon towards the arbiter.
module eth_fc_class #(
    parameter int SPACE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   i_en,
    input  logic                   i_tick,
    input  logic [SPACE_WIDTH-1:0] i_space,
    input  logic [15:0]            i_pause_thresh,
    input  logic [16:0]            i_resume_level,
    input  logic [15:0]            i_pause_time,
    input  logic [15:0]            i_load_time,
    input  logic                   i_grant_xoff,
    input  logic                   i_grant_xon,
    output logic                   o_want_xoff,
    output logic                   o_want_xon,
    output logic                   o_paused
);

    localparam int CW = ((SPACE_WIDTH > 16) ? SPACE_WIDTH : 16) + 1;

    localparam logic [0:0] C_RUN    = 1'b0;
    localparam logic [0:0] C_PAUSED = 1'b1;

    logic [CW-1:0] w_space_x;
    logic [CW-1:0] w_pause_x;
    logic [CW-1:0] w_resume_x;
    logic          w_refresh_due;

    logic          r_below;
    logic          r_above;
    logic [0:0]    r_state;
    logic [15:0]   r_remaining;

    assign w_space_x  = CW'(i_space);
    assign w_pause_x  = CW'(i_pause_thresh);
    assign w_resume_x = CW'(i_resume_level);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_below     <= 1'b0;
            r_above     <= 1'b0;
            r_state     <= C_RUN;
            r_remaining <= '0;
        end else if (clear) begin
            r_below     <= 1'b0;
            r_above     <= 1'b0;
            r_state     <= C_RUN;
            r_remaining <= '0;
        end else begin
            r_below <= (w_space_x < w_pause_x);
            r_above <= (w_space_x >= w_resume_x);
            // A grant in the same cycle as a quantum tick overrides the decrement.
            if (i_grant_xoff) begin
                r_state     <= C_PAUSED;
                r_remaining <= i_load_time;
            end else if (i_grant_xon) begin
                r_state     <= C_RUN;
                r_remaining <= '0;
            end else if (i_tick && (r_state == C_PAUSED) && (r_remaining != 16'd0)) begin
                r_remaining <= r_remaining - 16'd1;
            end
        end
    end

    assign w_refresh_due = (r_remaining <= (i_pause_time >> 1));

    // Disabling wins: a paused class with the enable low only ever asks for XON.
    assign o_want_xoff = i_en &&
                         (((r_state == C_RUN) && r_below) ||
                          ((r_state == C_PAUSED) && w_refresh_due && !r_above));
    assign o_want_xon  = (r_state == C_PAUSED) && (r_above || !i_en);
    assign o_paused    = (r_state == C_PAUSED);

endmodule

// File: rtl/eth_flow_ctrl_gen.sv
// RX flow-control request generator: per-class pause tracking, quantum
// prescaler, and the IDLE/REQ/HOLDOFF request arbiter towards the TX MAC.
module eth_flow_ctrl_gen
    import eth_fc_pkg::*;
#(
    parameter int NUM_CLASSES  = 1,
    parameter int SPACE_WIDTH  = 16,
    parameter int QUANTA_CLKS  = FC_QUANTA_1G,
    parameter int HOLDOFF_CLKS = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               pause_request_en,
    input  logic [15:0]                        pause_time,
    input  logic [15:0]                        pause_thresh,
    input  logic [15:0]                        resume_thresh,
    input  logic [NUM_CLASSES*SPACE_WIDTH-1:0] fifo_space,
    output logic [NUM_CLASSES-1:0]             class_paused,
    eth_flow_ctrl_gen_if.master                req_if
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int PW = $clog2(QUANTA_CLKS + 1);
    localparam int HW = $clog2(HOLDOFF_CLKS + 1);

    logic [PW-1:0]             r_presc;
    logic                      w_tick;

    logic [1:0]                r_state;
    logic [HW-1:0]             r_hold;
    logic                      r_req;
    logic [15:0]               r_time;
    logic [FC_MAX_CLASSES-1:0] r_vec;
    fc_kind_t                  r_kind;

    logic [16:0]               w_resume;
    logic                      w_ack;
    logic [NUM_CLASSES-1:0]    w_want_xoff;
    logic [NUM_CLASSES-1:0]    w_want_xon;
    logic [NUM_CLASSES-1:0]    w_grant_xoff;
    logic [NUM_CLASSES-1:0]    w_grant_xon;

    assign w_resume = fc_resume_level(pause_thresh, resume_thresh);

    assign w_tick = (r_presc == PW'(QUANTA_CLKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_presc <= '0;
        else if (clear || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    assign w_ack        = (r_state == S_REQ) && req_if.pause_ack;
    assign w_grant_xoff = (w_ack && (r_kind == FC_XOFF)) ? r_vec[NUM_CLASSES-1:0] : '0;
    assign w_grant_xon  = (w_ack && (r_kind == FC_XON))  ? r_vec[NUM_CLASSES-1:0] : '0;

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_class
        eth_fc_class #(
            .SPACE_WIDTH (SPACE_WIDTH)
        ) u_class (
            .clk            (clk),
            .reset          (reset),
            .clear          (clear),
            .i_en           (pause_request_en),
            .i_tick         (w_tick),
            .i_space        (fifo_space[g*SPACE_WIDTH +: SPACE_WIDTH]),
            .i_pause_thresh (pause_thresh),
            .i_resume_level (w_resume),
            .i_pause_time   (pause_time),
            .i_load_time    (r_time),
            .i_grant_xoff   (w_grant_xoff[g]),
            .i_grant_xon    (w_grant_xon[g]),
            .o_want_xoff    (w_want_xoff[g]),
            .o_want_xon     (w_want_xon[g]),
            .o_paused       (class_paused[g])
        );
    end

    // Request arbiter: the vector is latched at issue, so anything that arises
    // while a request is outstanding waits for the next pass through IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_req   <= 1'b0;
            r_time  <= '0;
            r_vec   <= '0;
            r_kind  <= FC_NONE;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_req   <= 1'b0;
            r_time  <= '0;
            r_vec   <= '0;
            r_kind  <= FC_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_want_xoff) begin
                        r_req   <= 1'b1;
                        r_time  <= pause_time;
                        r_vec   <= FC_MAX_CLASSES'(w_want_xoff);
                        r_kind  <= FC_XOFF;
                        r_state <= S_REQ;
                    end else if (|w_want_xon) begin
                        r_req   <= 1'b1;
                        r_time  <= '0;
                        r_vec   <= FC_MAX_CLASSES'(w_want_xon);
                        r_kind  <= FC_XON;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_time  <= '0;
                        r_vec   <= '0;
                        r_kind  <= FC_NONE;
                        r_hold  <= '0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_hold == HW'(HOLDOFF_CLKS - 1))
                        r_state <= S_IDLE;
                    else
                        r_hold <= r_hold + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_if.pause_req       = r_req;
    assign req_if.pause_time_req  = r_time;
    assign req_if.pause_class_vec = r_vec;

endmodule

// File: tb/tb_eth_flow_ctrl_gen.sv
// Directed bench for eth_flow_ctrl_gen: a single-class and a four-class
// instance share clock, reset and thresholds.
module tb_eth_flow_ctrl_gen;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        en;
    logic [15:0] ptime;
    logic [15:0] pthresh;
    logic [15:0] rthresh;
    logic [15:0] space1;
    logic [63:0] space4;
    logic [0:0]  paused1;
    logic [3:0]  paused4;

    int n_pass;
    int n_total;

    eth_flow_ctrl_gen_if if1 ();
    eth_flow_ctrl_gen_if if4 ();

    eth_flow_ctrl_gen #(
        .NUM_CLASSES(1), .SPACE_WIDTH(16), .QUANTA_CLKS(64), .HOLDOFF_CLKS(16)
    ) dut1 (
        .clk              (clk),
        .reset            (reset),
        .clear            (clear),
        .pause_request_en (en),
        .pause_time       (ptime),
        .pause_thresh     (pthresh),
        .resume_thresh    (rthresh),
        .fifo_space       (space1),
        .class_paused     (paused1),
        .req_if           (if1)
    );

    eth_flow_ctrl_gen #(
        .NUM_CLASSES(4), .SPACE_WIDTH(16), .QUANTA_CLKS(64), .HOLDOFF_CLKS(16)
    ) dut4 (
        .clk              (clk),
        .reset            (reset),
        .clear            (clear),
        .pause_request_en (en),
        .pause_time       (ptime),
        .pause_thresh     (pthresh),
        .resume_thresh    (rthresh),
        .fifo_space       (space4),
        .class_paused     (paused4),
        .req_if           (if4)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack1();
        if1.pause_ack = 1'b1;
        cyc(1);
        if1.pause_ack = 1'b0;
    endtask

    task automatic ack4();
        if4.pause_ack = 1'b1;
        cyc(1);
        if4.pause_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL rst_req1 got=%0b exp=0", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_time_req !== 16'h0) $display("FAIL rst_time1 got=%h exp=0000", if1.pause_time_req); else n_pass++;
        n_total++; if (if1.pause_class_vec !== 8'h00) $display("FAIL rst_vec1 got=%h exp=00", if1.pause_class_vec); else n_pass++;
        n_total++; if (paused1 !== 1'b0) $display("FAIL rst_paused1 got=%b exp=0", paused1); else n_pass++;
        n_total++; if (if4.pause_req !== 1'b0) $display("FAIL rst_req4 got=%0b exp=0", if4.pause_req); else n_pass++;
        n_total++; if (if4.pause_class_vec !== 8'h00) $display("FAIL rst_vec4 got=%h exp=00", if4.pause_class_vec); else n_pass++;
        n_total++; if (paused4 !== 4'h0) $display("FAIL rst_paused4 got=%b exp=0000", paused4); else n_pass++;
    endtask

    task automatic test_xoff_basic();
        en = 1'b1;
        cyc(4);
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL xoff_idle_req got=%0b exp=0", if1.pause_req); else n_pass++;
        space1 = 16'd99;
        cyc(1);
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL xoff_early_req got=%0b exp=0", if1.pause_req); else n_pass++;
        cyc(1);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL xoff_req got=%0b exp=1", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_time_req !== 16'h0020) $display("FAIL xoff_time got=%h exp=0020", if1.pause_time_req); else n_pass++;
        n_total++; if (if1.pause_class_vec !== 8'h01) $display("FAIL xoff_vec got=%h exp=01", if1.pause_class_vec); else n_pass++;
        cyc(5);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL xoff_hold_req got=%0b exp=1", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_time_req !== 16'h0020) $display("FAIL xoff_hold_time got=%h exp=0020", if1.pause_time_req); else n_pass++;
        n_total++; if (if1.pause_class_vec !== 8'h01) $display("FAIL xoff_hold_vec got=%h exp=01", if1.pause_class_vec); else n_pass++;
        n_total++; if (paused1 !== 1'b0) $display("FAIL xoff_pre_ack_paused got=%b exp=0", paused1); else n_pass++;
        ack1();
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL xoff_ack_req got=%0b exp=0", if1.pause_req); else n_pass++;
        n_total++; if (paused1 !== 1'b1) $display("FAIL xoff_ack_paused got=%b exp=1", paused1); else n_pass++;
    endtask

    task automatic test_refresh();
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        space1 = 16'd50;
        while (n < 17 * 64 && !got) begin
            cyc(1);
            n++;
            if (if1.pause_req === 1'b1) got = 1'b1;
        end
        n_total++; if (!got) $display("FAIL refresh_timeout got=none exp=req within %0d clks", 17 * 64); else n_pass++;
        n_total++; if (n < 960 || n > 1026) $display("FAIL refresh_latency got=%0d exp=960..1026", n); else n_pass++;
        n_total++; if (if1.pause_time_req !== 16'h0020) $display("FAIL refresh_time got=%h exp=0020", if1.pause_time_req); else n_pass++;
        n_total++; if (if1.pause_class_vec !== 8'h01) $display("FAIL refresh_vec got=%h exp=01", if1.pause_class_vec); else n_pass++;
        n_total++; if (paused1 !== 1'b1) $display("FAIL refresh_paused got=%b exp=1", paused1); else n_pass++;
        ack1();
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL refresh_ack_req got=%0b exp=0", if1.pause_req); else n_pass++;
        n_total++; if (paused1 !== 1'b1) $display("FAIL refresh_ack_paused got=%b exp=1", paused1); else n_pass++;
    endtask

    task automatic test_xon();
        space1 = 16'd250;
        cyc(16);
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL xon_holdoff_req got=%0b exp=0", if1.pause_req); else n_pass++;
        cyc(1);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL xon_req got=%0b exp=1", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_time_req !== 16'h0000) $display("FAIL xon_time got=%h exp=0000", if1.pause_time_req); else n_pass++;
        n_total++; if (if1.pause_class_vec !== 8'h01) $display("FAIL xon_vec got=%h exp=01", if1.pause_class_vec); else n_pass++;
        n_total++; if (paused1 !== 1'b1) $display("FAIL xon_pre_ack_paused got=%b exp=1", paused1); else n_pass++;
        ack1();
        n_total++; if (paused1 !== 1'b0) $display("FAIL xon_ack_paused got=%b exp=0", paused1); else n_pass++;
    endtask

    task automatic test_resume_fix_and_en();
        pthresh = 16'd100;
        rthresh = 16'd80;
        do_reset();
        space1 = 16'd50;
        cyc(2);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL hyst_xoff_req got=%0b exp=1", if1.pause_req); else n_pass++;
        ack1();
        space1 = 16'd100;
        cyc(30);
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL hyst_100_req got=%0b exp=0", if1.pause_req); else n_pass++;
        n_total++; if (paused1 !== 1'b1) $display("FAIL hyst_100_paused got=%b exp=1", paused1); else n_pass++;
        space1 = 16'd101;
        cyc(1);
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL hyst_101_early got=%0b exp=0", if1.pause_req); else n_pass++;
        cyc(1);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL hyst_101_req got=%0b exp=1", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_time_req !== 16'h0000) $display("FAIL hyst_101_time got=%h exp=0000", if1.pause_time_req); else n_pass++;
        ack1();
        n_total++; if (paused1 !== 1'b0) $display("FAIL hyst_xon_paused got=%b exp=0", paused1); else n_pass++;
        space1 = 16'd50;
        cyc(17);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL en_xoff_req got=%0b exp=1", if1.pause_req); else n_pass++;
        en = 1'b0;
        cyc(2);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL en_inflight_req got=%0b exp=1", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_time_req !== 16'h0020) $display("FAIL en_inflight_time got=%h exp=0020", if1.pause_time_req); else n_pass++;
        ack1();
        n_total++; if (paused1 !== 1'b1) $display("FAIL en_inflight_paused got=%b exp=1", paused1); else n_pass++;
        cyc(16);
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL en_holdoff_req got=%0b exp=0", if1.pause_req); else n_pass++;
        cyc(1);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL en_xon_req got=%0b exp=1", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_time_req !== 16'h0000) $display("FAIL en_xon_time got=%h exp=0000", if1.pause_time_req); else n_pass++;
        ack1();
        n_total++; if (paused1 !== 1'b0) $display("FAIL en_xon_paused got=%b exp=0", paused1); else n_pass++;
        cyc(100);
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL en_off_quiet got=%0b exp=0", if1.pause_req); else n_pass++;
        en = 1'b1;
        rthresh = 16'd200;
        space1 = 16'd300;
    endtask

    task automatic test_multi_class();
        space4 = {16'd300, 16'd300, 16'd300, 16'd300};
        do_reset();
        space4 = {16'd50, 16'd300, 16'd50, 16'd300};
        cyc(1);
        n_total++; if (if4.pause_req !== 1'b0) $display("FAIL mc_early_req got=%0b exp=0", if4.pause_req); else n_pass++;
        cyc(1);
        n_total++; if (if4.pause_req !== 1'b1) $display("FAIL mc_req got=%0b exp=1", if4.pause_req); else n_pass++;
        n_total++; if (if4.pause_class_vec !== 8'h0A) $display("FAIL mc_vec got=%h exp=0a", if4.pause_class_vec); else n_pass++;
        n_total++; if (if4.pause_time_req !== 16'h0020) $display("FAIL mc_time got=%h exp=0020", if4.pause_time_req); else n_pass++;
        ack4();
        n_total++; if (paused4 !== 4'b1010) $display("FAIL mc_paused got=%b exp=1010", paused4); else n_pass++;

        space4 = {16'd300, 16'd300, 16'd300, 16'd300};
        do_reset();
        space4 = {16'd300, 16'd300, 16'd300, 16'd50};
        cyc(2);
        n_total++; if (if4.pause_class_vec !== 8'h01) $display("FAIL mc_c0_vec got=%h exp=01", if4.pause_class_vec); else n_pass++;
        ack4();
        space4 = {16'd300, 16'd50, 16'd300, 16'd300};
        cyc(17);
        n_total++; if (if4.pause_req !== 1'b1) $display("FAIL mc_prio_req got=%0b exp=1", if4.pause_req); else n_pass++;
        n_total++; if (if4.pause_class_vec !== 8'h04) $display("FAIL mc_prio_vec got=%h exp=04", if4.pause_class_vec); else n_pass++;
        n_total++; if (if4.pause_time_req !== 16'h0020) $display("FAIL mc_prio_time got=%h exp=0020", if4.pause_time_req); else n_pass++;
        ack4();
        n_total++; if (paused4 !== 4'b0101) $display("FAIL mc_prio_paused got=%b exp=0101", paused4); else n_pass++;
        cyc(16);
        n_total++; if (if4.pause_req !== 1'b0) $display("FAIL mc_holdoff_req got=%0b exp=0", if4.pause_req); else n_pass++;
        cyc(1);
        n_total++; if (if4.pause_class_vec !== 8'h01) $display("FAIL mc_xon_vec got=%h exp=01", if4.pause_class_vec); else n_pass++;
        n_total++; if (if4.pause_time_req !== 16'h0000) $display("FAIL mc_xon_time got=%h exp=0000", if4.pause_time_req); else n_pass++;
        ack4();
        n_total++; if (paused4 !== 4'b0100) $display("FAIL mc_xon_paused got=%b exp=0100", paused4); else n_pass++;
        space4 = {16'd300, 16'd300, 16'd300, 16'd300};
    endtask

    task automatic test_reset_clear_mid_req();
        do_reset();
        space1 = 16'd50;
        cyc(2);
        ack1();
        space1 = 16'd250;
        cyc(17);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL rmid_setup_req got=%0b exp=1", if1.pause_req); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL rmid_req got=%0b exp=0", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_class_vec !== 8'h00) $display("FAIL rmid_vec got=%h exp=00", if1.pause_class_vec); else n_pass++;
        n_total++; if (paused1 !== 1'b0) $display("FAIL rmid_paused got=%b exp=0", paused1); else n_pass++;
        cyc(1);
        reset = 1'b0;
        cyc(2);

        space1 = 16'd50;
        cyc(2);
        ack1();
        space1 = 16'd250;
        cyc(17);
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL cmid_setup_req got=%0b exp=1", if1.pause_req); else n_pass++;
        clear = 1'b1;
        #1;
        n_total++; if (if1.pause_req !== 1'b1) $display("FAIL cmid_before_edge got=%0b exp=1", if1.pause_req); else n_pass++;
        cyc(1);
        clear = 1'b0;
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL cmid_req got=%0b exp=0", if1.pause_req); else n_pass++;
        n_total++; if (if1.pause_class_vec !== 8'h00) $display("FAIL cmid_vec got=%h exp=00", if1.pause_class_vec); else n_pass++;
        n_total++; if (paused1 !== 1'b0) $display("FAIL cmid_paused got=%b exp=0", paused1); else n_pass++;
        cyc(40);
        n_total++; if (if1.pause_req !== 1'b0) $display("FAIL cmid_no_xon got=%0b exp=0", if1.pause_req); else n_pass++;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        clk           = 1'b0;
        reset         = 1'b1;
        clear         = 1'b0;
        en            = 1'b0;
        ptime         = 16'h0020;
        pthresh       = 16'd100;
        rthresh       = 16'd200;
        space1        = 16'd300;
        space4        = {16'd300, 16'd300, 16'd300, 16'd300};
        if1.pause_ack = 1'b0;
        if4.pause_ack = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        test_reset();
        test_xoff_basic();
        test_refresh();
        test_xon();
        test_resume_fix_and_en();
        test_multi_class();
        test_reset_clear_mid_req();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
